button_arbiter: RTL and testbench
=================================

# button_arbiter

Collects N raw push-button levels and turns each press into exactly one one-shot event. It synchronises each input and detects its rising edge, then latches the press as pending. Pending presses are issued one at a time on a valid/ready port, with round-robin priority and a programmable dead-time between grants. It sits between the board buttons and the command/FSM logic that consumes single-cycle button events.

## Interface
- N, default 4: number of button inputs.
- IDW, default 2: width of button index; must equal ceil(log2 N).
- GAP, default 2: number of dead cycles inserted after each accepted grant (0 allowed).

- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- btn  input  N  raw, asynchronous button levels, 1 = pressed.
- out_ready  input  1  consumer can accept an event this cycle.
- out_valid  output  1  event offered.
- out_id  output  IDW  index of the offered button.
- pending  output  N  per-button latched-press flags.
- overrun  output  1  one-cycle pulse: a press was dropped.

## Operation
- **Reset state:** out_valid=0, out_id=0, pending=0, overrun=0, round-robin pointer ptr=0, FSM=IDLE, all synchroniser flops 0.
- **Input path, per button i:**
  - s1<=btn[i]; s2<=s1; prev<=s2.
  - rise[i] = s2 & ~prev, which is combinational and one cycle wide.
  - A level held through reset therefore counts as one press.
  - A level held indefinitely produces exactly one rise.
- **Pending flags:**
  - pending[i] sets on rise[i].
  - pending[i] clears on accept (out_valid & out_ready & out_id==i).
  - Rise and clear of the same i in one cycle: pending stays 1 and the new press is queued; no overrun.
  - Rise while pending[i]=1 and not being cleared: overrun=1 for one cycle, pending stays 1, and the press is dropped.
- **FSM states IDLE, OFFER, GAP:**
  - IDLE: if any pending, select the first set bit searching from ptr upward with wrap N-1→0. Register out_id, set out_valid=1, go to OFFER. Otherwise stay.
  - OFFER: hold out_valid=1 and out_id stable until out_ready=1. On accept:
    - out_valid<=0, clear pending[out_id], ptr<=(out_id+1) mod N.
    - If GAP==0, go to IDLE; else cnt<=GAP-1 and go to GAP.
  - GAP: out_valid=0. If cnt==0 go to IDLE, else cnt<=cnt-1.
- Selection considers only pending as registered. A rise in the same cycle as the IDLE decision is not eligible until the next cycle.
- Reset has priority over every other event in every state, and discards any in-flight offer and all pending presses.

## Timing
- Press sampled high first at edge E:
  - s1=1 at E, rise high during the cycle after E+1, pending[i]=1 after E+2.
  - out_valid=1 after E+3, provided the FSM is IDLE and no other button wins.
- out_valid and out_id are registered and change only on posedge. out_id is stable for the whole OFFER.
- Accept at edge A:
  - out_valid=0 after A.
  - Next out_valid no earlier than after edge A+GAP+1, so GAP=0 still gives one idle cycle.
- overrun is registered and asserts the edge after the offending rise cycle.
- Reset asserted at edge R: all outputs at reset values after R.

## Test plan
- **Single held press:** GAP=2, ready=1, btn[2] high from before edge 5 for 20 cycles → pending[2]=1 after edge 7; out_valid=1, out_id=2 during cycle after edge 8; accepted at edge 9; no further grant while held.
- **Simultaneous presses:** btn[0] and btn[3] rise at the same edge, ptr=0, ready=1 → grant id 0, then id 3 with out_valid rising exactly 3 edges after the first accept.
- **Round-robin:** after accepting id 1 (ptr=2), pending={0,3} → grants id 3, then id 0.
- **Backpressure and overrun:** out_ready=0 for 12 cycles while offering id 1; press, release, re-press btn[1] → out_valid/out_id unchanged throughout, overrun one-cycle pulse, pending[1] stays 1; after ready=1, one grant of id 1 and pending[1]=0.
- **Rise coincident with accept:** align rise[1] with the accept of id 1 → pending[1] remains 1, overrun=0, id 1 re-offered after the GAP.
- **Reset mid-offer:** assert reset during OFFER with btn[0] held → after reset edge out_valid=0, pending=0, ptr=0; after deassert at edge D, out_valid=1, out_id=0 after edge D+3.

Source files
------------

// File: rtl/button_arbiter.sv
// Debounce-free button front end: synchronises N raw button levels, latches each rising edge
// as a pending press and issues pending presses one at a time, round-robin, with a dead-time.
module button_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2,
  parameter int unsigned GAP = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   btn,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [N-1:0]   pending,
  output logic           overrun
);

  localparam int unsigned CW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StOffer, StGap} state_e;

  state_e         state;
  logic [N-1:0]   s1, s2, prev;
  logic [N-1:0]   rise, clr;
  logic [IDW-1:0] ptr, sel_id, id_inc;
  logic [CW-1:0]  cnt;
  logic           sel_found, accept;
  int unsigned    idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise   = s2 & ~prev;
  assign accept = (state == StOffer) && out_ready;
  assign id_inc = (32'(out_id) == N - 1) ? '0 : out_id + IDW'(1);

  always_comb begin
    clr = '0;
    if (accept) clr[out_id] = 1'b1;
  end

  // First registered pending bit at or above ptr, wrapping N-1 -> 0.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!sel_found && pending[idx[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      out_valid <= 1'b0;
      out_id    <= '0;
      pending   <= '0;
      overrun   <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      // A rise on the button being accepted re-queues instead of overrunning.
      pending <= (pending & ~clr) | rise;
      overrun <= |(rise & pending & ~clr);
      unique case (state)
        StIdle: begin
          if (sel_found) begin
            out_id    <= sel_id;
            out_valid <= 1'b1;
            state     <= StOffer;
          end
        end
        StOffer: begin
          if (accept) begin
            out_valid <= 1'b0;
            ptr       <= id_inc;
            if (GAP == 0) begin
              state <= StIdle;
            end else begin
              cnt   <= CW'(GAP - 1);
              state <= StGap;
            end
          end
        end
        StGap: begin
          if (cnt == '0) state <= StIdle;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_button_arbiter.sv
// Bench for button_arbiter: directed scenarios then random buttons/ready/reset, every cycle
// compared against a time-based reference model of presses, pending flags and grants.
module tb_button_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned GAP = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   btn;
  logic           out_ready;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic [N-1:0]   pending;
  logic           overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last three sampled button vectors, newest first.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pending;
  bit           m_valid;
  bit           m_overrun;
  int           m_id;
  int           m_ptr;
  longint       m_free;   // earliest edge at which a new grant may be decided
  longint       edge_n;

  button_arbiter #(.N(N), .IDW(IDW), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_id    (out_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back({N{1'b0}});
    m_pending = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_id      = 0;
    m_ptr     = 0;
    m_free    = 0;
  endtask

  // One clock edge: advance the model from pre-edge inputs, then compare after the edge.
  task automatic step();
    logic [N-1:0] press, clr, nxt;
    bit           acc;
    int           idx;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      model_reset();
    end else begin
      press     = hist[1] & ~hist[2];
      acc       = m_valid && out_ready;
      clr       = '0;
      if (acc) clr[m_id] = 1'b1;
      m_overrun = |(press & m_pending & ~clr);
      nxt       = (m_pending & ~clr) | press;
      if (acc) begin
        m_valid = 1'b0;
        m_ptr   = (m_id + 1) % N;
        m_free  = edge_n + GAP + 1;
      end else if (!m_valid && edge_n >= m_free) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (m_pending[idx]) begin
            m_valid = 1'b1;
            m_id    = idx;
            break;
          end
        end
      end
      m_pending = nxt;
      hist.push_front(btn);
      void'(hist.pop_back());
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_id", 32'(out_id), 32'(m_id));
    check("pending", 32'(pending), 32'(m_pending));
    check("overrun", 32'(overrun), 32'(m_overrun));
  endtask

  initial begin
    edge_n = 0;
    model_reset();
    reset = 1'b1; btn = '0; out_ready = 1'b0;
    step(); step();
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    reset = 1'b0;

    // Single held press on button 2.
    out_ready = 1'b1; btn = 4'b0100;
    step(); step(); step();
    check("held_pend2", 32'(pending[2]), 32'd1);
    step();
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_id", 32'(out_id), 32'd2);
    step();
    check("held_accepted", 32'(out_valid), 32'd0);
    repeat (15) step();
    check("held_no_regrant", 32'(out_valid), 32'd0);
    btn = '0;
    reset = 1'b1; step(); reset = 1'b0;

    // Simultaneous presses on 0 and 3 with ptr=0.
    btn = 4'b1001;
    repeat (4) step();
    check("simul_first_id", 32'(out_id), 32'd0);
    step();
    check("simul_acc", 32'(out_valid), 32'd0);
    step(); step();
    check("simul_gap", 32'(out_valid), 32'd0);
    step();
    check("simul_second_valid", 32'(out_valid), 32'd1);
    check("simul_second_id", 32'(out_id), 32'd3);
    step();
    btn = '0; repeat (4) step();

    // Round-robin: accept id 1 while 0 and 3 are pending.
    out_ready = 1'b0; btn = 4'b0010;
    repeat (4) step();
    btn = 4'b1011;
    repeat (3) step();
    out_ready = 1'b1;
    step();
    repeat (3) step();
    check("rr_id3", 32'(out_id), 32'd3);
    step();
    repeat (3) step();
    check("rr_id0", 32'(out_id), 32'd0);
    step();
    btn = '0; repeat (5) step();

    // Backpressure with a re-press causing an overrun.
    out_ready = 1'b0; btn = 4'b0010;
    repeat (4) step();
    check("bp_id1", 32'(out_id), 32'd1);
    btn = '0; repeat (3) step();
    btn = 4'b0010;
    step(); step(); step();
    check("bp_overrun", 32'(overrun), 32'd1);
    check("bp_pend1", 32'(pending[1]), 32'd1);
    step();
    check("bp_overrun_pulse", 32'(overrun), 32'd0);
    check("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_pend_clear", 32'(pending[1]), 32'd0);
    repeat (6) step();

    // Rise of button 1 on the same edge as the accept of id 1.
    btn = '0; repeat (3) step();
    out_ready = 1'b0; btn = 4'b0010;
    repeat (4) step();
    btn = '0; repeat (3) step();
    btn = 4'b0010;
    step(); step();
    out_ready = 1'b1;
    step();
    check("coin_pend1", 32'(pending[1]), 32'd1);
    check("coin_overrun", 32'(overrun), 32'd0);
    step(); step();
    check("coin_gap", 32'(out_valid), 32'd0);
    step();
    check("coin_reoffer", 32'(out_valid), 32'd1);
    check("coin_reoffer_id", 32'(out_id), 32'd1);
    btn = '0; repeat (4) step();

    // Reset mid-offer with button 0 held.
    out_ready = 1'b0; btn = 4'b0001;
    repeat (4) step();
    check("rst_offer", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    step();
    reset = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    check("rst_not_yet", 32'(out_valid), 32'd0);
    step();
    check("rst_regrant", 32'(out_valid), 32'd1);
    check("rst_regrant_id", 32'(out_id), 32'd0);

    // Random phase.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
